// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO pair, with MTHI/MTLO writes
module muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic div_q, neg_q, rneg_q;
  logic [XLEN-1:0] d_q, a_mag, b_mag, quo_f, rem_f;
  logic [2*XLEN-1:0] acc, acc_nx, res;
  logic [XLEN:0] sum;
  logic is_div, sgn, a_neg, b_neg;
  always_comb begin
    is_div = op[1];
    sgn = ~op[0];
    // a signed divide by zero keeps the raw dividend so the remainder comes out as a unchanged
    a_neg = sgn & a[XLEN-1] & ~(is_div & (b == '0));
    b_neg = sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // one shared adder: add for shift-add multiply, subtract for restoring divide
    sum = div_q ? acc[2*XLEN-1:XLEN-1] - {1'b0, d_q}
                : {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, d_q} : '0);
    acc_nx = div_q ? (sum[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                   : {sum, acc[XLEN-1:1]};
    quo_f = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_f = rneg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    res = div_q ? {rem_f, quo_f} : (neg_q ? -acc : acc);
    state_nx = state;
    if (state == IDLE) state_nx = (start && !flush) ? CALC : IDLE;
    else if (state == CALC) state_nx = flush ? IDLE : (cnt == 5'(ITER - 1)) ? FIX : CALC;
    else state_nx = IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      d_q <= '0;
      acc <= '0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      done <= state == FIX && !flush;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
        if (start && !flush) begin
          div_q <= is_div;
          neg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          d_q <= b_mag;
          acc <= {{XLEN{1'b0}}, a_mag};
          cnt <= '0;
        end
      end else if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 5'd1;
      end else if (!flush) begin
        {hi, lo} <= res;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors checked against a behavioural HI/LO model every cycle
module tb_muldiv_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_vec = 0, n_err = 0;
  logic chk_on = 1'b0;
  logic m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] pend = '0;
  int left = 0;

  muldiv_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
                  .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  function automatic logic [63:0] compute(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    if (o == 2'd0) begin
      p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      return p;
    end
    if (o == 2'd1) return {32'b0, x} * {32'b0, y};
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 2'd3) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (flush) m_busy = 1'b0;
        else if (left == 1) begin
          {m_hi, m_lo} = pend; m_busy = 1'b0; m_done = 1'b1;
        end else left--;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start && !flush) begin
          m_busy = 1'b1; left = 33; pend = compute(op, a, b);
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("hilo", {hi, lo}, {m_hi, m_lo});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bsy);
    lat = 0;
    bsy = busy ? 1 : 0;
    while (!done && lat < 40) begin
      cyc();
      lat++;
      if (busy) bsy++;
    end
  endtask

  task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] exp);
    int lat, bsy;
    check({nm, "_model"}, compute(o, x, y), exp);
    launch(o, x, y);
    wait_done(lat, bsy);
    check({nm, "_lat"}, 64'(lat), 64'd33);
    check({nm, "_busy_cycles"}, 64'(bsy), 64'd33);
    check({nm, "_res"}, {hi, lo}, exp);
  endtask

  initial begin
    cyc(); cyc();
    chk_on = 1'b1;
    rst_n = 1'b1;
    check("reset_state", {30'b0, busy, done, hi, lo}, 64'd0);
    run("mult", 2'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run("multu_b2b", 2'd1, 32'd3, 32'd4, 64'd12);
    run("div", 2'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run("div_neg_zero", 2'd2, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);
    run("divu_zero", 2'd3, 32'd7, 32'd0, 64'h00000007_FFFFFFFF);
    run("divu", 2'd3, 32'd100, 32'd7, 64'h00000002_0000000E);
    launch(2'd1, 32'd2, 32'd3);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9; lo_we = 1'b1; wdata = 32'hDEAD;
      end else begin
        start = 1'b0; lo_we = 1'b0;
      end
      cyc();
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) cyc();
    check("flush_keep", {hi, lo}, 64'h00000002_0000000E);
    launch(2'd1, 32'd5, 32'd5);
    for (int i = 0; i < 5; i++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("midop_reset", {30'b0, busy, done, hi, lo}, 64'd0);
    lo_we = 1'b1; wdata = 32'h1234;
    cyc();
    lo_we = 1'b0;
    check("mtlo", 64'(lo), 64'h1234);
    hi_we = 1'b1; wdata = 32'h5555;
    launch(2'd1, 32'd6, 32'd7);
    hi_we = 1'b0;
    check("mthi_with_start", 64'(hi), 64'h5555);
    for (int i = 0; i < 33; i++) cyc();
    check("start_write_overwritten", {hi, lo}, 64'd42);
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
